store_drain_buffer: RTL

Committed-store buffer between the LSU commit path and the data memory's store channel. It holds up to DEPTH retired stores in program order and drains them one at a time over the dmem store handshake, releasing each entry only when the memory returns its store completion. While stores wait, it answers a combinational byte-granular forwarding lookup for the load path so that younger loads observe buffered data.

---
 rtl/store_drain_buffer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/store_drain_buffer.sv
// store_drain_buffer
// Holds up to DEPTH committed stores in program order. It issues them one at a
// time on the dmem store channel, and frees an entry only when dmem returns the
// store completion. Buffered bytes are forwarded combinationally to the load
// path, and the youngest matching store wins for each byte.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            committed store push handshake
//   in_addr/in_data/in_strb      store byte address, lane-aligned data, byte enables
//   st_valid/st_ready            dmem store request handshake (head entry)
//   st_addr/st_wdata/st_wstrb    head entry, zero while no request is pending
//   st_resp_valid/st_resp_ready  dmem store completion handshake
//   fwd_addr                     load lookup address (doubleword granular)
//   fwd_hit/fwd_data/fwd_strb    merged buffered bytes for that doubleword
//   count                        occupied entries
//   drained                      empty and drain FSM idle
//
// state  | meaning
// S_IDLE | buffer empty, nothing offered to dmem
// S_REQ  | head entry offered on st_valid, waiting for st_ready
// S_WAIT | head entry accepted by dmem, waiting for its completion
module store_drain_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [63:0]                in_data,
    input  logic [7:0]                 in_strb,
    output logic                       st_valid,
    input  logic                       st_ready,
    output logic [ADDR_W-1:0]          st_addr,
    output logic [63:0]                st_wdata,
    output logic [7:0]                 st_wstrb,
    input  logic                       st_resp_valid,
    output logic                       st_resp_ready,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [63:0]                fwd_data,
    output logic [7:0]                 fwd_strb,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drained
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [63:0]        data_q [DEPTH];
    logic [7:0]         strb_q [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    logic               st_valid_q;
    logic               st_resp_ready_q;
    logic               push;
    logic               pop;
    logic               unused_fwd_lsb;

    // A pop in the same cycle does not free a slot for a push when full.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_WAIT) && st_resp_valid;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count_q <= count_nxt;
        end
    end

    // Entry storage is not reset. Occupancy is tracked by head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
            strb_q[tail] <= in_strb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            st_valid_q      <= 1'b0;
            st_resp_ready_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state      <= S_REQ;
                        st_valid_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (st_ready) begin
                        state           <= S_WAIT;
                        st_valid_q      <= 1'b0;
                        st_resp_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (st_resp_valid) begin
                        st_resp_ready_q <= 1'b0;
                        if (count_nxt != '0) begin
                            state      <= S_REQ;
                            st_valid_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    st_valid_q      <= 1'b0;
                    st_resp_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The head cannot move while a request is pending, so the fields stay stable.
    assign st_valid      = st_valid_q;
    assign st_resp_ready = st_resp_ready_q;
    assign st_addr       = st_valid_q ? addr_q[head] : '0;
    assign st_wdata      = st_valid_q ? data_q[head] : '0;
    assign st_wstrb      = st_valid_q ? strb_q[head] : '0;
    assign count         = count_q;
    assign drained       = (count_q == '0) && (state == S_IDLE);

    // Walk the entries from oldest to youngest so that younger bytes overwrite older ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_data = '0;
        fwd_strb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx][ADDR_W-1:3] == fwd_addr[ADDR_W-1:3])) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb_q[idx][b]) begin
                        fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
                        fwd_strb[b]        = 1'b1;
                    end
                end
            end
        end
    end

    assign fwd_hit        = |fwd_strb;
    assign unused_fwd_lsb = ^fwd_addr[2:0];

endmodule
